// File: rtl/nivel_pkg.sv
// nivel_pkg: shared types and helpers for the tank level conditioning stage.
//   - nivel_e      : FSM state encoding (3 bits)
//   - CODE_*       : 4-bit {al,a,m,b} level code for each valid state
//   - is_thermo    : 1 when a debounced code is a legal thermometer code
//   - code_to_state: maps a legal code to its state
package nivel_pkg;

    typedef enum logic [2:0] {
        VAZIO  = 3'd0,
        BAIXO  = 3'd1,
        MEDIO  = 3'd2,
        ALTO   = 3'd3,
        TRANSB = 3'd4,
        ERRO   = 3'd5
    } nivel_e;

    localparam logic [3:0] CODE_VAZIO  = 4'b0000;
    localparam logic [3:0] CODE_BAIXO  = 4'b0001;
    localparam logic [3:0] CODE_MEDIO  = 4'b0011;
    localparam logic [3:0] CODE_ALTO   = 4'b0111;
    localparam logic [3:0] CODE_TRANSB = 4'b1111;

    function automatic logic is_thermo(input logic [3:0] code);
        return (code == CODE_VAZIO) || (code == CODE_BAIXO) ||
               (code == CODE_MEDIO) || (code == CODE_ALTO)  ||
               (code == CODE_TRANSB);
    endfunction

    // Only meaningful for legal codes; anything else maps to ERRO.
    function automatic nivel_e code_to_state(input logic [3:0] code);
        nivel_e st;
        case (code)
            CODE_VAZIO:  st = VAZIO;
            CODE_BAIXO:  st = BAIXO;
            CODE_MEDIO:  st = MEDIO;
            CODE_ALTO:   st = ALTO;
            CODE_TRANSB: st = TRANSB;
            default:     st = ERRO;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: 2-flop synchroniser followed by a counting debouncer.
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   din  : asynchronous raw electrode input
//   dout : debounced stable value
// The stable value flips only after the synchronised input has disagreed
// with it for DEB_CYCLES consecutive cycles.
module debounce_bit #(
    parameter int DEB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            // Reaching DEB_CYCLES flips the stable value and restarts at 0.
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= din;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/sensor_nivel_filtro.sv
// sensor_nivel_filtro: conditions the four tank electrodes for the LED-matrix
// level display.
//   clk, rst                   : clock, synchronous active-high reset
//   raw_b, raw_m, raw_a, raw_al: asynchronous electrodes, 1 = wet
//   B, M, A, AL                : registered filtered level lines
//   erro                       : registered, 1 while in fault state
//   mudou                      : one-cycle pulse when the outputs change state
// Each electrode is debounced independently; the debounced code must be a
// thermometer code. A persistent illegal code forces the fault state, and a
// persistent legal code is required to leave it.
module sensor_nivel_filtro
    import nivel_pkg::*;
#(
    parameter int DEB_CYCLES = 1000,
    parameter int ERR_CYCLES = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_b,
    input  logic raw_m,
    input  logic raw_a,
    input  logic raw_al,
    output logic B,
    output logic M,
    output logic A,
    output logic AL,
    output logic erro,
    output logic mudou
);

    localparam int EW = $clog2(ERR_CYCLES);
    localparam logic [EW-1:0] ERR_LAST = EW'(ERR_CYCLES - 1);

    logic          deb_b, deb_m, deb_a, deb_al;
    logic [3:0]    code;
    logic          code_ok;
    nivel_e        code_st;

    nivel_e        state_q;
    logic [EW-1:0] err_cnt_q;
    logic [EW-1:0] ok_cnt_q;
    logic [3:0]    lvl_q;
    logic          erro_q;
    logic          mudou_q;

    debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b  (.clk(clk), .rst(rst), .din(raw_b),  .dout(deb_b));
    debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb_m  (.clk(clk), .rst(rst), .din(raw_m),  .dout(deb_m));
    debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a  (.clk(clk), .rst(rst), .din(raw_a),  .dout(deb_a));
    debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb_al (.clk(clk), .rst(rst), .din(raw_al), .dout(deb_al));

    always_comb begin
        code    = {deb_al, deb_a, deb_m, deb_b};
        code_ok = is_thermo(code);
        code_st = code_to_state(code);
    end

    // Outputs are loaded together with the state so they always show the
    // state being entered; mudou marks the first cycle of that new state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= VAZIO;
            err_cnt_q <= '0;
            ok_cnt_q  <= '0;
            lvl_q     <= CODE_VAZIO;
            erro_q    <= 1'b0;
            mudou_q   <= 1'b0;
        end else begin
            mudou_q <= 1'b0;
            if (state_q != ERRO) begin
                ok_cnt_q <= '0;
                if (code_ok) begin
                    err_cnt_q <= '0;
                    if (code_st != state_q) begin
                        state_q <= code_st;
                        lvl_q   <= code;
                        erro_q  <= 1'b0;
                        mudou_q <= 1'b1;
                    end
                end else if (err_cnt_q == ERR_LAST) begin
                    err_cnt_q <= '0;
                    state_q   <= ERRO;
                    lvl_q     <= 4'b0000;
                    erro_q    <= 1'b1;
                    mudou_q   <= 1'b1;
                end else begin
                    err_cnt_q <= err_cnt_q + 1'b1;
                end
            end else begin
                err_cnt_q <= '0;
                if (!code_ok) begin
                    ok_cnt_q <= '0;
                end else if (ok_cnt_q == ERR_LAST) begin
                    ok_cnt_q <= '0;
                    state_q  <= code_st;
                    lvl_q    <= code;
                    erro_q   <= 1'b0;
                    mudou_q  <= 1'b1;
                end else begin
                    ok_cnt_q <= ok_cnt_q + 1'b1;
                end
            end
        end
    end

    assign B     = lvl_q[0];
    assign M     = lvl_q[1];
    assign A     = lvl_q[2];
    assign AL    = lvl_q[3];
    assign erro  = erro_q;
    assign mudou = mudou_q;

endmodule

// File: tb/tb_sensor_nivel_filtro.sv
module tb_sensor_nivel_filtro;

    localparam int DEB = 4;
    localparam int ERR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw_b = 1'b0, raw_m = 1'b0, raw_a = 1'b0, raw_al = 1'b0;
    logic B, M, A, AL, erro, mudou;

    int checks   = 0;
    int failures = 0;
    int mudou_cnt = 0;

    // Behavioural reference: per-electrode pipelines, level as an integer.
    logic [3:0] s1_v, s2_v, st_v;
    int         run [4];
    int         lvl;
    int         in_err, err_run, ok_run;
    logic [3:0] exp_out;
    logic       exp_erro, exp_mudou;

    sensor_nivel_filtro #(.DEB_CYCLES(DEB), .ERR_CYCLES(ERR)) dut (
        .clk(clk), .rst(rst),
        .raw_b(raw_b), .raw_m(raw_m), .raw_a(raw_a), .raw_al(raw_al),
        .B(B), .M(M), .A(A), .AL(AL), .erro(erro), .mudou(mudou)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        s1_v = 4'b0; s2_v = 4'b0; st_v = 4'b0;
        for (int i = 0; i < 4; i++) run[i] = 0;
        lvl = 0; in_err = 0; err_run = 0; ok_run = 0;
        exp_out = 4'b0; exp_erro = 1'b0; exp_mudou = 1'b0;
    endtask

    // Advance the reference by one rising edge, using pre-edge values.
    task automatic model_step();
        int   ones;
        logic valid;
        if (rst) begin
            model_reset();
            return;
        end
        ones  = $countones(st_v);
        valid = (st_v == 4'((1 << ones) - 1));
        exp_mudou = 1'b0;
        if (in_err == 0) begin
            ok_run = 0;
            if (valid) begin
                err_run = 0;
                if (ones != lvl) begin
                    lvl = ones;
                    exp_mudou = 1'b1;
                end
            end else begin
                err_run++;
                if (err_run == ERR) begin
                    in_err = 1; err_run = 0; exp_mudou = 1'b1;
                end
            end
        end else begin
            if (valid) begin
                ok_run++;
                if (ok_run == ERR) begin
                    in_err = 0; ok_run = 0; lvl = ones; exp_mudou = 1'b1;
                end
            end else begin
                ok_run = 0;
            end
        end
        exp_out  = (in_err != 0) ? 4'b0 : 4'((1 << lvl) - 1);
        exp_erro = (in_err != 0);
        for (int i = 0; i < 4; i++) begin
            if (s2_v[i] != st_v[i]) begin
                run[i]++;
                if (run[i] == DEB) begin
                    st_v[i] = ~st_v[i];
                    run[i]  = 0;
                end
            end else begin
                run[i] = 0;
            end
        end
        s2_v = s1_v;
        s1_v = {raw_al, raw_a, raw_m, raw_b};
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("levels", {28'b0, AL, A, M, B}, {28'b0, exp_out});
        check("erro",   {31'b0, erro},  {31'b0, exp_erro});
        check("mudou",  {31'b0, mudou}, {31'b0, exp_mudou});
        if (mudou === 1'b1) mudou_cnt++;
    endtask

    task automatic set_raw(input logic [3:0] v);
        {raw_al, raw_a, raw_m, raw_b} = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        mudou_cnt = 0;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int n;
        model_reset();

        // Reset and idle
        set_raw(4'b0000);
        do_reset();
        check("reset_lvl", {28'b0, AL, A, M, B}, 32'h0);
        check("reset_erro", {31'b0, erro}, 32'h0);
        hold(20);
        check("idle_mudou_cnt", mudou_cnt, 0);
        check("idle_lvl", {28'b0, AL, A, M, B}, 32'h0);

        // Single rising step: latency counted with the sampling edge as 1
        set_raw(4'b0001);
        n = 0;
        do begin
            tick();
            n++;
        end while (B !== 1'b1 && n < 40);
        check("step_latency", n, DEB + 3);
        check("step_mudou_now", {31'b0, mudou}, 32'h1);
        hold(10);
        check("step_mudou_cnt", mudou_cnt, 1);

        // Short glitch is rejected
        set_raw(4'b0000);
        do_reset();
        set_raw(4'b0001);
        hold(DEB - 1);
        set_raw(4'b0000);
        hold(15);
        check("glitch_B", {31'b0, B}, 32'h0);
        check("glitch_mudou_cnt", mudou_cnt, 0);

        // Fill sequence
        do_reset();
        set_raw(4'b0001); hold(10);
        check("fill_1", {28'b0, AL, A, M, B}, 32'h1);
        set_raw(4'b0011); hold(10);
        check("fill_2", {28'b0, AL, A, M, B}, 32'h3);
        set_raw(4'b0111); hold(10);
        check("fill_3", {28'b0, AL, A, M, B}, 32'h7);
        set_raw(4'b1111); hold(10);
        check("fill_4", {28'b0, AL, A, M, B}, 32'hf);
        check("fill_mudou_cnt", mudou_cnt, 4);

        // Fault entry and exit
        set_raw(4'b0000);
        do_reset();
        set_raw(4'b0101); hold(15);
        check("fault_erro", {31'b0, erro}, 32'h1);
        check("fault_lvl", {28'b0, AL, A, M, B}, 32'h0);
        check("fault_mudou_cnt", mudou_cnt, 1);
        set_raw(4'b0011); hold(15);
        check("exit_erro", {31'b0, erro}, 32'h0);
        check("exit_lvl", {28'b0, AL, A, M, B}, 32'h3);
        check("exit_mudou_cnt", mudou_cnt, 2);

        // Reset in the middle of raw_m debounce; the count restarts afterwards
        set_raw(4'b0000);
        do_reset();
        set_raw(4'b0010);
        hold(4);
        rst = 1'b1;
        tick();
        check("midrst_lvl", {28'b0, AL, A, M, B}, 32'h0);
        check("midrst_erro", {31'b0, erro}, 32'h0);
        rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (erro !== 1'b1 && n < 60);
        // 2 sync + DEB debounce edges, then ERR edges of the illegal code
        check("midrst_fault_latency", n, 2 + DEB + ERR);

        // Randomised electrode activity against the reference
        set_raw(4'b0000);
        do_reset();
        for (int seg = 0; seg < 60; seg++) begin
            logic [3:0] v;
            v = {raw_al, raw_a, raw_m, raw_b};
            if ($urandom_range(0, 1) == 0)
                v = 4'((1 << $urandom_range(0, 4)) - 1);
            else
                v = v ^ 4'(1 << $urandom_range(0, 3));
            set_raw(v);
            hold($urandom_range(1, 12));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sensor_nivel_filtro.md
# sensor_nivel_filtro

Conditioning stage directly upstream of the LED-matrix level display. Takes the four raw tank electrodes (low, medium, high, overflow), synchronises and debounces each one, and checks that the combination is physically consistent. It then emits the clean level lines B, M, A, AL that drive the matrix display stage, plus an error flag and a change pulse. A persistent impossible combination is reported as a sensor fault instead of being passed downstream.

## Interface
- DEB_CYCLES, 1000: consecutive cycles a synchronised input must differ from its stable value before the stable value flips (≥2).
- ERR_CYCLES, 500: consecutive cycles a code must persist to enter or leave the fault state (≥2).
- clk  input  1  system clock; all logic on rising edge; one clock domain.
- rst  input  1  synchronous, active-high reset.
- raw_b, raw_m, raw_a, raw_al  input  1 each  asynchronous electrode inputs, 1 = wet.
- B, M, A, AL  output  1 each  registered, filtered level lines to the matrix display.
- erro  output  1  registered; 1 while in fault state.
- mudou  output  1  one-cycle pulse on every state change, including entry to and exit from fault.

## Operation
- Each raw input passes through a 2-flop synchroniser, then a debouncer:
  - Counter width is ceil(log2(DEB_CYCLES+1)).
  - If sync == stable, the counter clears to 0.
  - Otherwise it increments. When it would reach DEB_CYCLES, stable inverts and the counter clears in the same cycle.
- The debounced code {al,a,m,b} is valid only as a thermometer: 0000, 0001, 0011, 0111, 1111. Any other code is invalid.
- FSM states: VAZIO (0000), BAIXO (0001), MEDIO (0011), ALTO (0111), TRANSB (1111), ERRO.
- In a non-ERRO state:
  - A valid code different from the current state moves the FSM to that code's state on the next edge. Multi-level jumps are allowed.
  - An invalid code increments err_cnt; a valid code clears it.
  - When err_cnt reaches ERR_CYCLES-1 with the code still invalid, the FSM goes to ERRO and err_cnt clears.
- In ERRO:
  - A valid code increments ok_cnt; an invalid code clears it.
  - When ok_cnt reaches ERR_CYCLES-1 with the code still valid, the FSM goes to the state of that code and ok_cnt clears.
- Output decode (registered from next-state):
  - Each non-ERRO state drives {AL,A,M,B} equal to its code, with erro=0.
  - ERRO drives B=M=A=AL=0, erro=1.
- mudou = 1 for exactly the cycle in which the outputs first show the new state.

## Timing
- Reset: synchronisers, stable values, all counters = 0. State = VAZIO. B=M=A=AL=0, erro=0, mudou=0. Reset dominates every other event.
- Clean valid step (raw change held steady): outputs change DEB_CYCLES+3 cycles after the first clock edge that samples the new raw value.
  - Breakdown: 2 synchroniser cycles + DEB_CYCLES + 1 output register.
- Glitch shorter than DEB_CYCLES cycles: no output change, no mudou.
- Several electrodes settling on different cycles: each debounces independently. Intermediate codes are evaluated every cycle.
  - Transient invalid codes shorter than ERR_CYCLES cause no fault.
  - Transient valid codes do cause state moves.
- Fault entry: ERR_CYCLES cycles of an invalid debounced code, then one output cycle.
- Fault exit: ERR_CYCLES cycles of a valid debounced code, then one output cycle.
- Invalid code interrupted by a valid code for one cycle: err_cnt restarts from 0.
- Reset asserted mid-debounce or mid-fault count: everything returns to reset values on that edge. Counting restarts after deassertion.

## Structure
- Package nivel_pkg holds:
  - State enum (VAZIO, BAIXO, MEDIO, ALTO, TRANSB, ERRO), 3-bit encoding.
  - 4-bit level code constants for each valid state.
  - Function is_thermo(code).
- Sub-module debounce_bit (parameter DEB_CYCLES; ports clk, rst, din, dout) contains the synchroniser, counter and stable flop. It is instantiated four times.
- Top contains the validity check, the err_cnt/ok_cnt counters, the FSM and the output registers.

## Test plan
All scenarios use DEB_CYCLES=4, ERR_CYCLES=3.
- Reset, then raw inputs held 0000 for 20 cycles → outputs 0000, erro=0, mudou never 1.
- raw_b rises at cycle 10 and is held → B=1 at cycle 17, mudou=1 at cycle 17 only.
- raw_b pulses high for 3 cycles → B stays 0, no mudou.
- Fill sequence 0001→0011→0111→1111, each step held 10 cycles → outputs track each code, exactly 4 mudou pulses, AL=1 last.
- Debounced code 0101 held → ERRO after 3 cycles (B=M=A=AL=0, erro=1, one mudou); then 0011 held → after 3 cycles MEDIO (M=B=1, erro=0, one mudou).
- rst pulsed mid-debounce of raw_m, then raw held → all outputs 0 on the reset edge; the 4-cycle debounce restarts from 0 after release.
